// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Shift-add multiply, restoring divide, MADD/MSUB accumulate, valid/ready handshake.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod;
  logic               neg_res, neg_rem;

  logic accept, arith_go, handshake, is_div;
  logic signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign req_ready  = (state == S_IDLE) & ~flush & rst;
  assign accept     = req_valid & req_ready;
  assign arith_go   = accept & ~req_op[3];
  assign resp_valid = (state == S_DONE);
  assign handshake  = resp_valid & resp_ready & ~flush;
  assign is_div     = (op_q[2:1] == 2'b01);

  assign signed_op = ~req_op[0];
  assign a_neg     = signed_op & req_a[WIDTH-1];
  assign b_neg     = signed_op & req_b[WIDTH-1];
  assign a_abs     = a_neg ? -req_a : req_a;
  assign b_abs     = b_neg ? -req_b : req_b;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (arith_go) state_next = S_CALC;
      S_CALC: begin
        if (flush) state_next = S_IDLE;
        else if (cnt == CW'(WIDTH-1)) state_next = S_FIX;
      end
      S_FIX:  state_next = flush ? S_IDLE : S_DONE;
      S_DONE: if (flush || resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // prod holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_s, fix_val;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prod_s = neg_res ? -prod : prod;
    quo    = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem    = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    // divide by zero: remainder already equals the dividend, quotient forced to all ones
    if (b_q == '0) quo = '1;
    case (op_q[2:1])
      2'b00:   fix_val = prod_s;
      2'b01:   fix_val = {rem, quo};
      2'b10:   fix_val = {hi, lo} + prod_s;
      default: fix_val = {hi, lo} - prod_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      resp_hi <= '0;
      resp_lo <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
    end else begin
      busy <= (state_next != S_IDLE);
      if (accept && req_op == 4'd8) hi <= req_a;
      if (accept && req_op == 4'd9) lo <= req_a;
      if (arith_go) begin
        op_q    <= req_op[2:0];
        a_q     <= a_abs;
        b_q     <= b_abs;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        cnt     <= '0;
        if (req_op[2:1] == 2'b01) prod <= {{WIDTH{1'b0}}, a_abs};
        else                      prod <= {{WIDTH{1'b0}}, b_abs};
      end
      if (state == S_CALC) begin
        prod <= is_div ? div_next : mul_next;
        cnt  <= cnt + 1'b1;
      end
      if (state == S_FIX && !flush) begin
        resp_hi <= fix_val[2*WIDTH-1:WIDTH];
        resp_lo <= fix_val[WIDTH-1:0];
      end
      if (handshake) begin
        hi <= resp_hi;
        lo <= resp_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed self-checking bench for mdu_iter (WIDTH = 32).
// Expected results come from a plain-arithmetic model of HI/LO semantics.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = '0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         flush = 1'b0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_hi, resp_lo, hi, lo;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hi(resp_hi),
    .resp_lo(resp_lo), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] h, input logic [W-1:0] l);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      0: p = sa * sb;
      1: p = ua * ub;
      2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4: p = {h, l} + 64'(sa * sb);
      5: p = {h, l} + ua * ub;
      6: p = {h, l} - 64'(sa * sb);
      7: p = {h, l} - ua * ub;
      default: p = {h, l};
    endcase
    return p;
  endfunction

  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic [63:0] exp);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'(op); req_a = a; req_b = b;
    #1 check("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    k = 0;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("latency_op%0d", op), 64'(k), 64'(W + 1));
    check($sformatf("resp_op%0d", op), {resp_hi, resp_lo}, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("resp_stable", {resp_hi, resp_lo}, exp);
      check("hilo_before_hs", {hi, lo}, {m_hi, m_lo});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("hilo_commit_op%0d", op), {hi, lo}, exp);
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
    {m_hi, m_lo} = exp;
  endtask

  task automatic move_to(input int op, input logic [W-1:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'(op); req_a = a; req_b = '0;
    @(negedge clk);
    req_valid = 1'b0;
    if (op == 8) m_hi = a;
    else if (op == 9) m_lo = a;
    check($sformatf("hilo_op%0d", op), {hi, lo}, {m_hi, m_lo});
    check("no_resp_busy", {62'd0, resp_valid, busy}, 64'd0);
  endtask

  logic [W-1:0] ra, rb;
  int rop, sel, seen;

  initial begin
    #1 check("reset_outputs", {60'd0, req_ready, resp_valid, busy, 1'b0}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #12 rst = 1'b1;

    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001);
    run_op(0, -32'sd3, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2, -32'sd7, 32'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3, 32'd7, 32'd0, 0, 64'h0000_0007_FFFF_FFFF);
    run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h0000_0000_8000_0000);
    run_op(2, -32'sd9, 32'd0, 0, 64'hFFFF_FFF7_FFFF_FFFF);
    move_to(8, 32'd1);
    move_to(9, 32'hFFFF_FFFF);
    run_op(5, 32'd1, 32'd1, 0, 64'h0000_0002_0000_0000);
    run_op(6, 32'd1, 32'd1, 0, 64'h0000_0001_FFFF_FFFF);
    run_op(1, 32'd5, 32'd6, 5, 64'h0000_0000_0000_001E);

    // flush during CALC
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'd100; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 check("req_ready_flush", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_idle", {61'd0, busy, resp_valid, req_ready}, 64'd1);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check("flush_no_resp", 64'(seen), 64'd0);

    // flush with a request in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd8; req_a = 32'hDEAD_BEEF; flush = 1'b1;
    #1 check("idle_flush_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_op = 4'd0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush_hilo", {hi, lo}, {m_hi, m_lo});
    check("idle_flush_busy", 64'(busy), 64'd0);

    // flush wins over a DONE handshake
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd11; req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    while (!resp_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    check("done_flush_resp", {32'd0, resp_lo}, 64'd143);
    resp_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; flush = 1'b0;
    check("done_flush_hilo", {hi, lo}, {m_hi, m_lo});
    check("done_flush_valid", {62'd0, resp_valid, busy}, 64'd0);

    // randomized ops against the model
    for (int t = 0; t < 40; t++) begin
      rop = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = ra >> 24; rb = rb >> 28; end
      if (rop <= 7) run_op(rop, ra, rb, int'($urandom_range(0, 2)), model(rop, ra, rb, m_hi, m_lo));
      else move_to(rop, ra);
    end

    // reset in the middle of CALC
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'd123; req_b = 32'd456;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_ctrl", {61'd0, req_ready, resp_valid, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_resp", {resp_hi, resp_lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_release", {62'd0, req_ready, busy}, 64'd2);
    run_op(7, 32'd3, 32'd4, 0, model(7, 32'd3, 32'd4, m_hi, m_lo));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
